seg7_count_sequencer: RTL and testbench

//   Run/pause/step controller for the 4-bit display counter and its seven-segment output on an 8-in/8-out pin tile.

---
 rtl/seg7_ctrl_pkg.sv | 29 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_count_sequencer.sv | 151 +++++++++++++++
 tb/tb_seg7_count_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_ctrl_pkg.sv
// Shared types and constants for the seven-segment count sequencer:
// FSM state encoding, rate select codes and the hex-to-segment table.
package seg7_ctrl_pkg;

    localparam int unsigned COUNT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned BTN_W   = 4;
    localparam int unsigned LVL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    localparam logic [1:0] RATE_SLOW = 2'd0;
    localparam logic [1:0] RATE_MED  = 2'd1;
    localparam logic [1:0] RATE_FAST = 2'd2;
    localparam logic [1:0] RATE_MAX  = 2'd3;

    // Segments {g,f,e,d,c,b,a}, active-high; entry 0 sits in the low slice.
    localparam logic [15:0][SEG_W-1:0] SEG7_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [SEG_W-1:0] SEG7_ZERO = 7'h3F;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to seven-segment decoder; the caller registers the result.
module hex_to_seg7
    import seg7_ctrl_pkg::*;
(
    input  logic [COUNT_W-1:0] hex_i,
    output logic [SEG_W-1:0]   seg_c_o
);

    assign seg_c_o = SEG7_LUT[hex_i];

endmodule

// File: rtl/seg7_count_sequencer.sv
// Run/pause/step controller for a 4-bit display counter with a registered
// seven-segment output and a sticky wrap flag on the decimal point.
module seg7_count_sequencer
    import seg7_ctrl_pkg::*;
#(
    parameter int unsigned          PRESCALE_W = 12,
    parameter logic [COUNT_W-1:0]   TOP        = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               step_i,
    input  logic               clear_i,
    input  logic               dir_i,
    input  logic [1:0]         rate_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [SEG_W-1:0]   seg_o,
    output logic               dp_o,
    output logic [1:0]         state_o
);

    // Button vector layout: {clear, step, stop, start}
    logic [BTN_W-1:0] btn_s1_q, btn_s2_q, btn_s3_q;
    logic [LVL_W-1:0] lvl_s1_q, lvl_s2_q;

    state_e                state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  dp_q, dp_d;
    logic [SEG_W-1:0]      seg_q;
    logic [SEG_W-1:0]      seg_c;

    logic [BTN_W-1:0]      btn_rise_c;
    logic                  start_c, stop_c, step_c, clear_c;
    logic                  dir_c;
    logic [1:0]            rate_c;
    logic [PRESCALE_W-1:0] tick_mask_c;
    logic                  tick_c;
    logic                  advance_c;

    // Input synchronisers plus the extra button stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            btn_s3_q <= '0;
            lvl_s1_q <= '0;
            lvl_s2_q <= '0;
        end else begin
            btn_s1_q <= {clear_i, step_i, stop_i, start_i};
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            lvl_s1_q <= {rate_i, dir_i};
            lvl_s2_q <= lvl_s1_q;
        end
    end

    assign btn_rise_c = btn_s2_q & ~btn_s3_q;
    assign start_c    = btn_rise_c[0];
    assign stop_c     = btn_rise_c[1];
    assign step_c     = btn_rise_c[2];
    assign clear_c    = btn_rise_c[3];
    assign dir_c      = lvl_s2_q[0];
    assign rate_c     = lvl_s2_q[2:1];

    // An all-zero mask makes every RUN cycle a tick
    always_comb begin
        tick_mask_c = '0;
        case (rate_c)
            RATE_SLOW: tick_mask_c = {PRESCALE_W{1'b1}};
            RATE_MED:  tick_mask_c = {PRESCALE_W{1'b1}} >> 2;
            RATE_FAST: tick_mask_c = {PRESCALE_W{1'b1}} >> 4;
            default:   tick_mask_c = '0;
        endcase
    end

    assign tick_c = ((presc_q & tick_mask_c) == tick_mask_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            dp_q    <= 1'b0;
            seg_q   <= SEG7_ZERO;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            dp_q    <= dp_d;
            seg_q   <= seg_c;
        end
    end

    // Command priority clear > stop > start > step; a command suppresses a same-cycle tick
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        dp_d      = dp_q;
        advance_c = 1'b0;

        if (state_q == ST_RUN) begin
            presc_d = presc_q + PRESCALE_W'(1);
        end

        if (clear_c) begin
            state_d = ST_IDLE;
            count_d = '0;
            dp_d    = 1'b0;
            presc_d = '0;
        end else if (stop_c && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (start_c && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            presc_d = '0;
        end else if (((state_q == ST_RUN) && tick_c) || ((state_q == ST_PAUSE) && step_c)) begin
            advance_c = 1'b1;
        end

        if (advance_c) begin
            if (dir_c) begin
                if (count_q == TOP) begin
                    count_d = '0;
                    dp_d    = 1'b1;
                end else begin
                    count_d = count_q + COUNT_W'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = TOP;
                    dp_d    = 1'b1;
                end else begin
                    count_d = count_q - COUNT_W'(1);
                end
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex_i   (count_q),
        .seg_c_o (seg_c)
    );

    assign count_o = count_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_seg7_count_sequencer.sv
// Bench for seg7_count_sequencer: cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seg7_count_sequencer;

    localparam int unsigned PW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0, stop_i = 1'b0, step_i = 1'b0, clear_i = 1'b0;
    logic       dir_i = 1'b1;
    logic [1:0] rate_i = 2'd3;
    logic [3:0] count_o;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [1:0] state_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seg7_count_sequencer #(.PRESCALE_W(PW), .TOP(4'hF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .stop_i  (stop_i),
        .step_i  (step_i),
        .clear_i (clear_i),
        .dir_i   (dir_i),
        .rate_i  (rate_i),
        .count_o (count_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .state_o (state_o)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int period(input logic [1:0] r);
        case (r)
            2'd0:    return 2 ** PW;
            2'd1:    return 2 ** (PW - 2);
            2'd2:    return 2 ** (PW - 4);
            default: return 1;
        endcase
    endfunction

    // Reference model: states 0=IDLE 1=RUN 2=PAUSE; a button acts two edges after
    // the edge that first samples it high, a level likewise.
    int         m_state, m_count, m_run;
    bit         m_dp, m_adv, m_dir;
    logic [6:0] m_seg;
    logic [3:0] bh1, bh2, bh3, cmd;
    logic [2:0] lh1, lh2;
    logic [1:0] m_rate;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_count = 0; m_run = 0; m_dp = 1'b0; m_seg = 7'h3F;
            bh1 = '0; bh2 = '0; bh3 = '0; lh1 = '0; lh2 = '0;
        end else begin
            cmd    = bh2 & ~bh3;
            m_dir  = lh2[0];
            m_rate = lh2[2:1];
            m_seg  = seg_tab[m_count];
            m_adv  = 1'b0;
            if (cmd[3]) begin
                m_state = 0; m_count = 0; m_dp = 1'b0;
            end else if (cmd[1] && m_state == 1) begin
                m_state = 2;
            end else if (cmd[0] && m_state != 1) begin
                m_state = 1; m_run = 0;
            end else if (m_state == 1) begin
                m_adv = ((m_run + 1) % period(m_rate)) == 0;
                m_run++;
            end else if (m_state == 2 && cmd[2]) begin
                m_adv = 1'b1;
            end
            if (m_adv) begin
                if (m_dir) begin
                    m_count = (m_count + 1) % 16;
                    if (m_count == 0) m_dp = 1'b1;
                end else begin
                    m_count = (m_count + 15) % 16;
                    if (m_count == 15) m_dp = 1'b1;
                end
            end
            bh3 = bh2; bh2 = bh1; bh1 = {clear_i, step_i, stop_i, start_i};
            lh2 = lh1; lh1 = {rate_i, dir_i};
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("cyc_state", int'(state_o), m_state);
            chk("cyc_count", int'(count_o), m_count);
            chk("cyc_seg",   int'(seg_o),   int'(m_seg));
            chk("cyc_dp",    int'(dp_o),    int'(m_dp));
        end
    end

    // Mask bits {clear, step, stop, start}, held for one sampling edge
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {clear_i, step_i, stop_i, start_i} = m;
        @(negedge clk);
        {clear_i, step_i, stop_i, start_i} = 4'b0000;
    endtask

    task automatic wait_state(input logic [1:0] s, input int maxc, input string nm);
        int c = 0;
        while (state_o != s && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(nm, int'(state_o), int'(s));
    endtask

    task automatic wait_count(input logic [3:0] v, input int maxc, input string nm);
        int c = 0;
        while (count_o != v && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(nm, int'(count_o), int'(v));
    endtask

    task automatic measure_first_advance(input logic [1:0] r, input int exp, input string nm);
        int n = 0;
        press(4'b1000);
        wait_state(2'b00, 8, {nm, "_idle"});
        rate_i = r;
        dir_i  = 1'b1;
        press(4'b0001);
        wait_state(2'b01, 8, {nm, "_run"});
        while (count_o == 4'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state_o), 0);
        chk("rst_count", int'(count_o), 0);
        chk("rst_seg",   int'(seg_o),   'h3F);
        chk("rst_dp",    int'(dp_o),    0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Every-cycle advance, 15 -> 0 wrap, segment lag
        rate_i = 2'd3; dir_i = 1'b1;
        press(4'b0001);
        wait_state(2'b01, 8, "A_run");
        wait_count(4'hF, 40, "A_reach15");
        @(negedge clk);
        chk("A_wrap_count", int'(count_o), 0);
        chk("A_wrap_dp",    int'(dp_o),    1);
        chk("A_wrap_seg",   int'(seg_o),   'h71);
        @(negedge clk);
        chk("A_seg_lag",    int'(seg_o),   'h3F);
        chk("A_model_dp",   int'(m_dp),    1);

        // Async reset mid-RUN, no clock edge needed
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("R_state", int'(state_o), 0);
        chk("R_count", int'(count_o), 0);
        chk("R_seg",   int'(seg_o),   'h3F);
        chk("R_dp",    int'(dp_o),    0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pause at 5, then three steps
        rate_i = 2'd0; dir_i = 1'b1;
        press(4'b0001);
        wait_state(2'b01, 8, "B_run");
        wait_count(4'd5, 120, "B_reach5");
        press(4'b0010);
        wait_state(2'b10, 8, "B_pause");
        chk("B_hold5", int'(count_o), 5);
        repeat (3) begin
            press(4'b0100);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("B_count8", int'(count_o), 8);
        chk("B_seg8",   int'(seg_o),   'h7F);
        chk("B_model8", m_count, 8);

        // Step down from 0 in PAUSE, then clear
        press(4'b1000);
        wait_state(2'b00, 8, "C_idle");
        dir_i = 1'b0; rate_i = 2'd0;
        press(4'b0001);
        wait_state(2'b01, 8, "C_run");
        press(4'b0010);
        wait_state(2'b10, 8, "C_pause");
        chk("C_at0", int'(count_o), 0);
        press(4'b0100);
        repeat (4) @(negedge clk);
        chk("C_count15", int'(count_o), 15);
        chk("C_seg15",   int'(seg_o),   'h71);
        chk("C_dp",      int'(dp_o),    1);
        press(4'b1000);
        repeat (4) @(negedge clk);
        chk("C_clr_state", int'(state_o), 0);
        chk("C_clr_count", int'(count_o), 0);
        chk("C_clr_dp",    int'(dp_o),    0);

        // Simultaneous commands
        press(4'b1001);
        repeat (4) @(negedge clk);
        chk("D_clr_start_state", int'(state_o), 0);
        chk("D_clr_start_count", int'(count_o), 0);
        dir_i = 1'b1;
        press(4'b0001);
        wait_state(2'b01, 8, "D_run");
        press(4'b0011);
        wait_state(2'b10, 8, "D_stop_start_pause");

        // First-advance latency per rate
        measure_first_advance(2'd0, 16, "E_rate0_latency");
        measure_first_advance(2'd1, 4,  "E_rate1_latency");

        // Step ignored in RUN
        press(4'b1000);
        wait_state(2'b00, 8, "F_idle");
        rate_i = 2'd0;
        press(4'b0001);
        wait_state(2'b01, 8, "F_run");
        press(4'b0100);
        repeat (4) @(negedge clk);
        chk("F_step_in_run_count", int'(count_o), 0);
        chk("F_step_in_run_state", int'(state_o), 1);

        // Rate and direction changes mid-run, tracked by the model
        rate_i = 2'd2;
        repeat (10) @(negedge clk);
        dir_i = 1'b0; rate_i = 2'd1;
        repeat (20) @(negedge clk);
        rate_i = 2'd3;
        repeat (20) @(negedge clk);
        press(4'b0010);
        repeat (6) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
